// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and HALT sequencing controller for the 5-stage pipeline.
// Optional feature macro: PIPE_FWD_EN (enables EX/MEM/WB forwarding, load-use-only stalls).
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic                   id_rs1_used,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_rs2_used,
    input  logic [REG_AW-1:0]      id_dst,
    input  logic                   id_wb_we,
    input  logic                   id_load,
    input  logic                   id_hlt,
    input  logic                   ex_redirect,
    output logic                   stall_if_id,
    output logic                   bubble_ex,
    output logic                   flush_if_id,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              we;
        logic              ld;
    } entry_t;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    entry_t ex_q, mem_q, wb_q, ex_d;
    state_e state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic src_match(entry_t e, logic [REG_AW-1:0] s, logic used,
                                       logic valid);
        return e.v & e.we & (e.dst != '0) & (e.dst == s) & used & valid;
    endfunction

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic data_hazard;

    always_comb begin
        a_ex  = src_match(ex_q,  id_rs1, id_rs1_used, id_valid);
        a_mem = src_match(mem_q, id_rs1, id_rs1_used, id_valid);
        a_wb  = src_match(wb_q,  id_rs1, id_rs1_used, id_valid);
        b_ex  = src_match(ex_q,  id_rs2, id_rs2_used, id_valid);
        b_mem = src_match(mem_q, id_rs2, id_rs2_used, id_valid);
        b_wb  = src_match(wb_q,  id_rs2, id_rs2_used, id_valid);
    end

`ifdef PIPE_FWD_EN
    // Only a load still in EX cannot be forwarded; one bubble moves it to MEM.
    always_comb begin
        data_hazard = (a_ex | b_ex) & ex_q.ld;
        fwd_a_sel   = a_ex ? 2'b01 : a_mem ? 2'b10 : a_wb ? 2'b11 : 2'b00;
        fwd_b_sel   = b_ex ? 2'b01 : b_mem ? 2'b10 : b_wb ? 2'b11 : 2'b00;
    end
`else
    // No write-through in the regfile, so a WB-stage producer still blocks.
    always_comb begin
        data_hazard = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        case (state_q)
            StRun: begin
                if (ex_redirect) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (data_hazard) begin
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + STALL_CNT_W'(1);
                    end
                end else if (id_valid && id_hlt) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
                if (!(ex_q.v | mem_q.v | wb_q.v)) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    // HALT itself never occupies a tracker slot.
    always_comb begin
        if (bubble_ex || id_hlt || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = '{v: 1'b1, dst: id_dst, we: id_wb_we, ld: id_load};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halted    = (state_q == StHalted);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random bench for pipe_hazard_ctrl against an in-flight-list model.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic        id_rs1_used = 1'b0;
    logic [4:0]  id_rs2 = '0;
    logic        id_rs2_used = 1'b0;
    logic [4:0]  id_dst = '0;
    logic        id_wb_we = 1'b0;
    logic        id_load = 1'b0;
    logic        id_hlt = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        stall_if_id, bubble_ex, flush_if_id, halted;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl #(.REG_AW(5), .STALL_CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .id_dst      (id_dst),
        .id_wb_we    (id_wb_we),
        .id_load     (id_load),
        .id_hlt      (id_hlt),
        .ex_redirect (ex_redirect),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .flush_if_id (flush_if_id),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: list of in-flight producers, index 0 youngest (one cycle past ID).
    typedef struct {
        bit v;
        int dst;
        bit we;
        bit ld;
    } rec_t;

    rec_t inflight[$];
    int   mstate;   // 0 running, 1 draining, 2 parked
    int   mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t e;
        e = '{v: 1'b0, dst: 0, we: 1'b0, ld: 1'b0};
        inflight.delete();
        for (int i = 0; i < 3; i++) inflight.push_back(e);
        mstate = 0;
        mcnt   = 0;
    endtask

    function automatic bit reads(rec_t r, int s, bit used, bit v);
        return v && used && r.v && r.we && r.dst != 0 && r.dst == s;
    endfunction

    task automatic drive_idle();
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_dst = 0; id_wb_we = 0; id_load = 0; id_hlt = 0; ex_redirect = 0;
    endtask

    task automatic cycle(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int dst, input bit we, input bit ld, input bit hlt,
                         input bit red);
        bit   hz, e_stall, e_bub, e_flush;
        int   fa, fb;
        rec_t nr;
        id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2);
        id_rs2_used = u2; id_dst = 5'(dst); id_wb_we = we; id_load = ld;
        id_hlt = hlt; ex_redirect = red;
        @(negedge clk);
        hz = 0; fa = 0; fb = 0;
        if (FWD) begin
            hz = (reads(inflight[0], rs1, u1, v) || reads(inflight[0], rs2, u2, v))
                 && inflight[0].ld;
            for (int i = 2; i >= 0; i--) begin
                if (reads(inflight[i], rs1, u1, v)) fa = i + 1;
                if (reads(inflight[i], rs2, u2, v)) fb = i + 1;
            end
        end else begin
            foreach (inflight[i])
                if (reads(inflight[i], rs1, u1, v) || reads(inflight[i], rs2, u2, v)) hz = 1;
        end
        e_stall = 0; e_bub = 0; e_flush = 0;
        if (mstate != 0) begin
            e_stall = 1; e_bub = 1;
        end else if (red) begin
            e_flush = 1; e_bub = 1;
        end else if (hz) begin
            e_stall = 1; e_bub = 1;
        end
        chk("stall_if_id", 32'(stall_if_id), 32'(e_stall));
        chk("bubble_ex",   32'(bubble_ex),   32'(e_bub));
        chk("flush_if_id", 32'(flush_if_id), 32'(e_flush));
        chk("fwd_a_sel",   32'(fwd_a_sel),   32'(fa));
        chk("fwd_b_sel",   32'(fwd_b_sel),   32'(fb));
        chk("halted",      32'(halted),      32'(mstate == 2));
        chk("stall_cnt",   32'(stall_cnt),   32'(mcnt));
        if (mstate == 0) begin
            if (!red && hz) begin
                if (mcnt < 65535) mcnt++;
            end else if (!red && v && hlt) begin
                mstate = 1;
            end
        end else if (mstate == 1) begin
            if (!inflight[0].v && !inflight[1].v && !inflight[2].v) mstate = 2;
        end
        nr = '{v: 1'b0, dst: 0, we: 1'b0, ld: 1'b0};
        if (!e_bub && !hlt && v) nr = '{v: 1'b1, dst: dst, we: we, ld: ld};
        @(posedge clk);
        #1;
        inflight.push_front(nr);
        void'(inflight.pop_back());
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        #2;
        chk("rst_halted",  32'(halted),      32'd0);
        chk("rst_cnt",     32'(stall_cnt),   32'd0);
        chk("rst_stall",   32'(stall_if_id), 32'd0);
        chk("rst_bubble",  32'(bubble_ex),   32'd0);
        chk("rst_flush",   32'(flush_if_id), 32'd0);
        chk("rst_fwd",     32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // LW r5 ; ADD r6,r5,r7
        cycle(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        for (int i = 0; i < (FWD ? 2 : 4); i++) cycle(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        chk("t1_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd3);

        // ADD r3 ; SUB r4,r3,r1
        do_reset();
        cycle(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        for (int i = 0; i < (FWD ? 1 : 4); i++) cycle(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
        chk("t2_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd3);

        // r0 is never a hazard
        do_reset();
        cycle(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 1, 4, 1, 0, 0, 0);
        chk("t3_cnt", 32'(stall_cnt), 32'd0);

        // load-use and redirect in the same cycle
        do_reset();
        cycle(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        cycle(1, 5, 1, 7, 1, 6, 1, 0, 0, 1);
        chk("t4_cnt", 32'(stall_cnt), 32'd0);

        // HALT with LW in EX
        do_reset();
        cycle(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        chk("t5_halted", 32'(halted), 32'd1);
        idle(3);
        chk("t5_park", 32'({halted, stall_if_id}), 32'd3);

        // reset mid-drain
        do_reset();
        cycle(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        do_reset();
        cycle(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        chk("t6_stall", 32'(stall_cnt), 32'd0);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (mstate == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 40) == 0,
                      mstate == 0 && $urandom_range(0, 9) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
